// File: rtl/ptp_b_if.sv
// Handshake bundle between the word source / beat consumer and ptp_b.
// Signal names are as seen from ptp_b; the slave modport is the block itself.
interface ptp_b_if #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned CHUNK_W = 8
);
   logic               serialise_i;
   logic               load_i;
   logic [WORD_W-1:0]  value_i;
   logic               ready_o;
   logic [CHUNK_W-1:0] value_o;
   logic               valid_o;
   logic               ack_i;
   logic               last_o;
   logic               done_o;

   modport slave (
      input  serialise_i, load_i, value_i, ack_i,
      output ready_o, value_o, valid_o, last_o, done_o
   );

   modport master (
      output serialise_i, load_i, value_i, ack_i,
      input  ready_o, value_o, valid_o, last_o, done_o
   );
endinterface

// File: rtl/ptp_b.sv
// ptp_b: splits a core word into MSB-first beats for the narrow output pins,
// either CHUNK_W bits per beat or one bit per beat (serial mode).
module ptp_b #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned CHUNK_W = 8
) (
   input  logic   clk_i,
   input  logic   reset_i,
   ptp_b_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] BYTE_BEATS = CNT_W'(WORD_W / CHUNK_W);
   localparam logic [CNT_W-1:0] SER_BEATS  = CNT_W'(WORD_W);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q;
   logic [WORD_W-1:0]  shift_q;
   logic [WORD_W-1:0]  shift_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               serial_q;
   logic [CHUNK_W-1:0] value_q;
   logic [CHUNK_W-1:0] value_d;
   logic               ready_q;
   logic               valid_q;
   logic               last_q;
   logic               done_q;

   // Beat presented for a given shift-register image and mode.
   function automatic logic [CHUNK_W-1:0] chunk_of(input logic [WORD_W-1:0] w,
                                                   input logic s);
      logic [CHUNK_W-1:0] r;
      if (s) begin
         r    = '0;
         r[0] = w[WORD_W-1];
      end else begin
         r = w[WORD_W-1 -: CHUNK_W];
      end
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] beats_of(input logic s);
      return s ? SER_BEATS : BYTE_BEATS;
   endfunction

   // Next shift image and the beat it exposes, used when a beat is accepted.
   always_comb begin
      shift_d = serial_q ? (shift_q << 1) : (shift_q << CHUNK_W);
      value_d = chunk_of(shift_d, serial_q);
   end

   // Control FSM; every output is a register so no input reaches an output combinationally.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         serial_q <= 1'b0;
         value_q  <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.load_i) begin
                  shift_q  <= bus.value_i;
                  serial_q <= bus.serialise_i;
                  cnt_q    <= beats_of(bus.serialise_i);
                  value_q  <= chunk_of(bus.value_i, bus.serialise_i);
                  last_q   <= (beats_of(bus.serialise_i) == CNT_W'(1));
                  valid_q  <= 1'b1;
                  ready_q  <= 1'b0;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               if (bus.ack_i) begin
                  if (cnt_q == CNT_W'(1)) begin
                     shift_q <= '0;
                     cnt_q   <= '0;
                     value_q <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_q - CNT_W'(1);
                     value_q <= value_d;
                     last_q  <= (cnt_q == CNT_W'(2));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.value_o = value_q;
   assign bus.valid_o = valid_q;
   assign bus.last_o  = last_q;
   assign bus.done_o  = done_q;
endmodule

// File: tb/tb_ptp_b.sv
// Scoreboard bench for ptp_b: expected beats are queued at load time and
// checked as the consumer accepts them; accepted beats are also re-packed
// MSB-first to confirm the word round-trips.
module tb_ptp_b;
   typedef struct {
      logic [7:0] val;
      logic       last;
   } beat_t;

   typedef struct {
      logic [31:0] w;
      logic        s;
   } word_t;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;
   logic mon_en  = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   beat_t sb[$];
   word_t wq[$];

   logic [31:0] rx_word   = '0;
   logic        done_pend = 1'b0;
   logic        prev_hold = 1'b0;
   logic [7:0]  prev_val  = '0;

   ptp_b_if #(.WORD_W(32), .CHUNK_W(8)) bus ();

   ptp_b #(.WORD_W(32), .CHUNK_W(8)) u_dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Consumer-side monitor, sampling on the falling edge.
   always @(negedge clk_i) begin
      beat_t e;
      word_t wd;
      if (reset_i || !mon_en) begin
         done_pend = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("done", bus.done_o, done_pend);
         if (prev_hold) begin
            chk("hold_value", bus.value_o, prev_val);
            chk("hold_valid", bus.valid_o, 1'b1);
         end
         if (!bus.valid_o) begin
            chk("last_idle", bus.last_o, 1'b0);
            chk("value_idle", bus.value_o, 8'h00);
         end
         done_pend = 1'b0;
         prev_hold = bus.valid_o && !bus.ack_i;
         prev_val  = bus.value_o;
         if (bus.valid_o && bus.ack_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", bus.valid_o, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("beat", bus.value_o, e.val);
               chk("last", bus.last_o, e.last);
               if (wq.size() != 0) begin
                  if (wq[0].s) rx_word = {rx_word[30:0], bus.value_o[0]};
                  else         rx_word = {rx_word[23:0], bus.value_o};
                  if (e.last) begin
                     wd = wq.pop_front();
                     chk("roundtrip", rx_word, wd.w);
                     rx_word = '0;
                  end
               end
               if (e.last) done_pend = 1'b1;
            end
         end
      end
   end

   // Wait for ready, present one word, queue its expected beats.
   task automatic send_word(input logic [31:0] w, input logic s);
      int unsigned n = 0;
      beat_t b;
      word_t wd;
      while (!bus.ready_o && n < 200) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("load_ready", bus.ready_o, 1'b1);
      bus.load_i      = 1'b1;
      bus.value_i     = w;
      bus.serialise_i = s;
      wd.w = w;
      wd.s = s;
      wq.push_back(wd);
      if (s) begin
         for (int i = 0; i < 32; i++) begin
            b.val  = {7'b0, w[31-i]};
            b.last = (i == 31);
            sb.push_back(b);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            b.val  = w[31-8*i -: 8];
            b.last = (i == 3);
            sb.push_back(b);
         end
      end
      @(posedge clk_i); #1;
      bus.load_i = 1'b0;
      chk("busy_ready", bus.ready_o, 1'b0);
      chk("busy_valid", bus.valid_o, 1'b1);
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while ((sb.size() != 0 || !bus.ready_o) && n < 500) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("drain", (sb.size() == 0) && bus.ready_o, 1'b1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", bus.ready_o, 1'b1);
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_last",  bus.last_o,  1'b0);
      chk("rst_done",  bus.done_o,  1'b0);
      chk("rst_value", bus.value_o, 8'h00);
   endtask

   initial begin
      bus.load_i      = 1'b0;
      bus.value_i     = '0;
      bus.serialise_i = 1'b0;
      bus.ack_i       = 1'b1;
      #23;
      chk_reset_outputs();
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      mon_en = 1'b1;

      // Byte mode, continuous ack.
      send_word(32'hDEADBEEF, 1'b0);
      wait_idle();

      // Serial mode, continuous ack.
      send_word(32'h80000001, 1'b1);
      wait_idle();

      // Backpressure on beat 2.
      send_word(32'h12345678, 1'b0);
      @(posedge clk_i); #1;
      bus.ack_i = 1'b0;
      repeat (5) begin
         @(posedge clk_i); #1;
      end
      bus.ack_i = 1'b1;
      wait_idle();

      // load_i and serialise_i disturbances while busy.
      send_word(32'hCAFEF00D, 1'b0);
      bus.load_i      = 1'b1;
      bus.value_i     = 32'hFFFFFFFF;
      bus.serialise_i = 1'b1;
      @(posedge clk_i); #1;
      bus.serialise_i = 1'b0;
      @(posedge clk_i); #1;
      bus.serialise_i = 1'b1;
      bus.load_i      = 1'b0;
      @(posedge clk_i); #1;
      bus.serialise_i = 1'b0;
      wait_idle();

      // Back-to-back: second load lands in the done_o cycle.
      send_word(32'h0F1E2D3C, 1'b0);
      send_word(32'h00000003, 1'b1);
      wait_idle();

      // Asynchronous reset mid-word.
      send_word(32'hA5A5A5A5, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      reset_i = 1'b1;
      sb.delete();
      wq.delete();
      rx_word = '0;
      #1;
      chk_reset_outputs();
      @(posedge clk_i); #3;
      reset_i = 1'b0;
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      chk_reset_outputs();

      send_word(32'h01020304, 1'b0);
      wait_idle();

      repeat (3) begin
         @(posedge clk_i); #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ptp_b.md
Name: ptp_b

Overview:
- Output-side partner to the RAM data-input assembler.
- Takes a 32-bit word from the Manchester Baby core (RAM/accumulator read-out) and splits it into chunks for the narrow external output pins.
- Two chunk modes: 8-bit chunks (4 beats) or 1-bit serial (32 beats).
- Chunk order is MSB-first, matching the order in which the input assembler packs words, so output and input streams round-trip unchanged.

Parameters:
- WORD_W, 32, word width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, chunk width in byte mode; also the width of value_o.

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge.
- reset_i  input  1  reset, asynchronous, active-high.
- serialise_i  input  1  mode select: 1 = 1-bit serial, 0 = CHUNK_W-bit chunks. Sampled only when a load is accepted.
- load_i  input  1  load request; word accepted when load_i && ready_o.
- value_i  input  WORD_W  word to send.
- ready_o  output  1  block idle and able to accept a load.
- value_o  output  CHUNK_W  current chunk.
- valid_o  output  1  value_o holds a valid beat.
- ack_i  input  1  consumer accepts the beat when valid_o && ack_i.
- last_o  output  1  current beat is the final beat of the word.
- done_o  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, any time, including mid-word):
  - ready_o=1; valid_o=0; last_o=0; done_o=0; value_o=0.
  - Internal shift register and beat counter cleared; state = IDLE.
  - Any in-flight word is discarded; no done_o pulse is issued for it.
- States: IDLE and SEND.
- IDLE, load_i=1:
  - On that edge, capture value_i into the shift register and latch the mode from serialise_i.
  - Load the beat counter with 4 (WORD_W/CHUNK_W) in byte mode, or 32 (WORD_W) in serial mode.
  - Next cycle: state SEND, ready_o=0, valid_o=1.
- IDLE, load_i=0: outputs hold. valid_o=0 and value_o=0.
- Beat contents:
  - Byte mode: value_o = shift register top CHUNK_W bits.
  - Serial mode: value_o = {zeros, shift register MSB}; upper bits are always 0.
- SEND, ack_i=0:
  - All outputs held stable: value_o, valid_o, last_o.
  - No timeout; the block waits indefinitely.
- SEND, ack_i=1, not last beat:
  - Shift left by CHUNK_W (byte mode) or by 1 (serial mode); decrement the counter.
  - The next beat is valid the following cycle, with no bubble.
  - Sustained ack_i=1 gives 4 or 32 consecutive beats.
- last_o:
  - Asserted exactly while valid_o=1 and counter==1.
  - Always 0 when valid_o=0.
- SEND, ack_i=1 on the last beat:
  - Next cycle: state IDLE, valid_o=0, last_o=0, value_o=0, ready_o=1, done_o=1 for exactly one cycle.
  - Minimum load-to-load spacing: N beats + 1 idle cycle.
- Ignored inputs:
  - load_i while in SEND is ignored; the latched word and mode are unaffected.
  - A serialise_i change mid-word has no effect until the next accepted load.
- A load accepted in the same cycle that done_o is high is legal (ready_o is already 1).
- ack_i while valid_o=0 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset_i asynchronously mid-cycle → immediately ready_o=1, valid_o=0, last_o=0, done_o=0, value_o=0x00.
- Byte mode, ack_i held 1: load 0xDEADBEEF with serialise_i=0 → beats 0xDE, 0xAD, 0xBE, 0xEF on 4 consecutive cycles; last_o only on 0xEF; done_o pulses the next cycle; ready_o=1.
- Serial mode, ack_i held 1: load 0x80000001 with serialise_i=1 → 32 beats: 0x01, then 30×0x00, then 0x01; last_o only on beat 32; value_o[7:1] always 0.
- Backpressure: byte mode 0x12345678, ack_i=0 for 5 cycles on beat 2 → 0x34 held stable with valid_o=1 throughout; then 0x56 and 0x78 follow after ack.
- Ignored inputs: while sending 0xCAFEF00D, pulse load_i with value_i=0xFFFFFFFF and toggle serialise_i → output stream is still 0xCA, 0xFE, 0xF0, 0x0D.
- Reset mid-word: reset after beat 2 of 0xA5A5A5A5 → outputs cleared and no done_o. A later load of 0x01020304 → beats 0x01, 0x02, 0x03, 0x04. Feeding these bytes to the input assembler reproduces 0x01020304.
